// File: rtl/ahb_apb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ahb_apb_pkg                                                   |
// | Brief    : Shared AHB codes, bridge region map and burst helpers for the |
// |            AHB-to-APB bridge.                                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  // Region k starts at REGION_BASE + k*REGION_STRIDE and spans REGION_SIZE bytes
  localparam logic [31:0] REGION_BASE   = 32'h8000_0000;
  localparam logic [31:0] REGION_STRIDE = 32'h0400_0000;
  localparam logic [31:0] REGION_SIZE   = 32'h0400_0000;

  typedef enum logic [1:0] {
    ERR_IDLE = 2'd0,
    ERR_ONE  = 2'd1,
    ERR_TWO  = 2'd2
  } err_state_t;

  // Number of beats in a burst; 0 means unbounded (INCR)
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_SINGLE:               burst_beats = 5'd1;
      HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd16;
      default:                     burst_beats = 5'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_addr_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ahb_addr_decoder                                              |
// | Brief    : Combinational haddr -> one-hot peripheral region select.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ahb_addr_decoder
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int NUM_SEL = 3
) (
  input  logic [ADDR_W-1:0]  haddr,
  output logic [NUM_SEL-1:0] sel,
  output logic               mapped
);

  // One comparator per region: unsigned offset from the base below the region size
  for (genvar k = 0; k < NUM_SEL; k++) begin : g_region
    localparam logic [ADDR_W-1:0] c_base =
      ADDR_W'(REGION_BASE) + ADDR_W'(k) * ADDR_W'(REGION_STRIDE);
    logic [ADDR_W-1:0] w_offset;
    assign w_offset = haddr - c_base;
    assign sel[k]   = (w_offset < ADDR_W'(REGION_SIZE));
  end

  assign mapped = |sel;

endmodule
`default_nettype wire

// File: rtl/ahb_slave_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ahb_slave_if                                                  |
// | Brief    : AHB subordinate front end of the AHB-to-APB bridge: transfer  |
// |            qualification, address/data pipeline, region decode, burst   |
// |            checking and optional two-cycle ERROR response.              |
// | Config   : AHB_SLV_ERR_RESP_EN - enables the ERROR response FSM         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ahb_slave_if
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SEL = 3
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic               hwrite,
  input  logic               hreadyin,
  input  logic [1:0]         htrans,
  input  logic [2:0]         hsize,
  input  logic [2:0]         hburst,
  input  logic [ADDR_W-1:0]  haddr,
  input  logic [DATA_W-1:0]  hwdata,
  input  logic               hready_bridge,
  input  logic [DATA_W-1:0]  hrdata_bridge,
  output logic               hreadyout,
  output logic [1:0]         hresp,
  output logic [DATA_W-1:0]  hrdata,
  output logic               valid,
  output logic [NUM_SEL-1:0] tempselx,
  output logic [ADDR_W-1:0]  haddr_1,
  output logic [ADDR_W-1:0]  haddr_2,
  output logic [DATA_W-1:0]  hwdata_1,
  output logic [DATA_W-1:0]  hwdata_2,
  output logic               hwrite_reg,
  output logic               hwrite_reg_1,
  output logic               proto_err
);

  logic [NUM_SEL-1:0] w_sel;
  logic               w_mapped;
  logic               w_err_idle;
  logic               w_accept;
  logic               w_nonseq;
  logic               w_seq;
  logic               w_viol;
  logic [2:0]         r_burst;
  logic               r_in_burst;
  logic [3:0]         r_beat_cnt;
  logic [ADDR_W-1:0]  r_prev_addr;
  logic [4:0]         w_new_beats;
  logic [3:0]         w_load_cnt;
  logic [ADDR_W-1:0]  w_inc;
  logic [ADDR_W:0]    w_next_sum;
  logic [ADDR_W-1:0]  w_wrap_mask;
  logic               w_is_incr;
  logic               w_is_wrap;
  logic               w_incr_bad;
  logic               w_wrap_bad;

  ahb_addr_decoder #(
    .ADDR_W  (ADDR_W),
    .NUM_SEL (NUM_SEL)
  ) u_decoder (
    .haddr  (haddr),
    .sel    (w_sel),
    .mapped (w_mapped)
  );

  // Transfers are only taken while the error response is not in progress
  assign w_accept = hreadyin & (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) & w_err_idle;
  assign w_nonseq = w_accept & (htrans == HTRANS_NONSEQ);
  assign w_seq    = w_accept & (htrans == HTRANS_SEQ);

  // Select and valid read as zero while reset is held
  assign tempselx = hresetn ? w_sel : '0;
  assign valid    = hresetn & w_accept & w_mapped;
  assign hrdata   = hrdata_bridge;

  // Burst rule checks for a SEQ beat against the previous accepted beat
  assign w_new_beats = burst_beats(hburst);
  assign w_load_cnt  = (w_new_beats == 5'd0) ? 4'd0 : 4'(w_new_beats - 5'd1);
  assign w_inc       = ADDR_W'(1) << hsize;
  assign w_next_sum  = {1'b0, r_prev_addr} + {1'b0, w_inc};
  assign w_wrap_mask = (ADDR_W'(burst_beats(r_burst)) << hsize) - ADDR_W'(1);
  assign w_is_incr   = r_burst[0];
  assign w_is_wrap   = ~r_burst[0] & (r_burst != HBURST_SINGLE);
  // Carry out of the top bit means the burst crossed the end of the address space
  assign w_incr_bad  = w_next_sum[ADDR_W] | (w_next_sum[ADDR_W-1:0] != haddr);
  assign w_wrap_bad  = (haddr & ~w_wrap_mask) != (r_prev_addr & ~w_wrap_mask);
  assign w_viol      = w_seq & (~r_in_burst
                              | ((r_burst != HBURST_INCR) & (r_beat_cnt == 4'd0))
                              | (w_is_incr & w_incr_bad)
                              | (w_is_wrap & w_wrap_bad));

  // Address/data/direction pipeline advances on every ready cycle
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr_1      <= '0;
      haddr_2      <= '0;
      hwdata_1     <= '0;
      hwdata_2     <= '0;
      hwrite_reg   <= 1'b0;
      hwrite_reg_1 <= 1'b0;
    end else if (hreadyin) begin
      haddr_1      <= haddr;
      haddr_2      <= haddr_1;
      hwdata_1     <= hwdata;
      hwdata_2     <= hwdata_1;
      hwrite_reg   <= hwrite;
      hwrite_reg_1 <= hwrite_reg;
    end
  end

  // Burst context: type, remaining beats and last accepted address
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_in_burst  <= 1'b0;
      r_burst     <= HBURST_SINGLE;
      r_beat_cnt  <= 4'd0;
      r_prev_addr <= '0;
    end else if (w_nonseq) begin
      r_in_burst  <= 1'b1;
      r_burst     <= hburst;
      r_beat_cnt  <= w_load_cnt;
      r_prev_addr <= haddr;
    end else if (w_seq) begin
      if (r_beat_cnt != 4'd0) begin
        r_beat_cnt <= r_beat_cnt - 4'd1;
      end
      r_prev_addr <= haddr;
    end else if (hreadyin && htrans == HTRANS_IDLE) begin
      r_in_burst <= 1'b0;
    end
  end

  // Sticky burst-protocol violation flag
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      proto_err <= 1'b0;
    end else if (w_viol) begin
      proto_err <= 1'b1;
    end
  end

`ifdef AHB_SLV_ERR_RESP_EN
  err_state_t r_state;
  logic       r_err_ready;
  logic [1:0] r_hresp;

  // Two-cycle ERROR response: wait state with ERROR, then ready with ERROR
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state     <= ERR_IDLE;
      r_err_ready <= 1'b1;
      r_hresp     <= HRESP_OKAY;
    end else begin
      case (r_state)
        ERR_IDLE: begin
          if (w_accept && (!w_mapped || w_viol)) begin
            r_state     <= ERR_ONE;
            r_err_ready <= 1'b0;
            r_hresp     <= HRESP_ERROR;
          end
        end
        ERR_ONE: begin
          r_state     <= ERR_TWO;
          r_err_ready <= 1'b1;
          r_hresp     <= HRESP_ERROR;
        end
        default: begin
          r_state     <= ERR_IDLE;
          r_err_ready <= 1'b1;
          r_hresp     <= HRESP_OKAY;
        end
      endcase
    end
  end

  assign w_err_idle = (r_state == ERR_IDLE);
  assign hreadyout  = w_err_idle ? hready_bridge : r_err_ready;
  assign hresp      = r_hresp;
`else
  assign w_err_idle = 1'b1;
  assign hreadyout  = hready_bridge;
  assign hresp      = HRESP_OKAY;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ahb_slave_if                                               |
// | Brief    : Self-checking bench for ahb_slave_if with a transaction-level |
// |            reference model (directed scenarios plus random bursts).     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ahb_slave_if;

`ifdef AHB_SLV_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        hclk;
  logic        hresetn;
  logic        hwrite;
  logic        hreadyin;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hready_bridge;
  logic [31:0] hrdata_bridge;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        valid;
  logic [2:0]  tempselx;
  logic [31:0] haddr_1, haddr_2, hwdata_1, hwdata_2;
  logic        hwrite_reg, hwrite_reg_1;
  logic        proto_err;

  ahb_slave_if #(.ADDR_W(32), .DATA_W(32), .NUM_SEL(3)) dut (
    .hclk          (hclk),
    .hresetn       (hresetn),
    .hwrite        (hwrite),
    .hreadyin      (hreadyin),
    .htrans        (htrans),
    .hsize         (hsize),
    .hburst        (hburst),
    .haddr         (haddr),
    .hwdata        (hwdata),
    .hready_bridge (hready_bridge),
    .hrdata_bridge (hrdata_bridge),
    .hreadyout     (hreadyout),
    .hresp         (hresp),
    .hrdata        (hrdata),
    .valid         (valid),
    .tempselx      (tempselx),
    .haddr_1       (haddr_1),
    .haddr_2       (haddr_2),
    .hwdata_1      (hwdata_1),
    .hwdata_2      (hwdata_2),
    .hwrite_reg    (hwrite_reg),
    .hwrite_reg_1  (hwrite_reg_1),
    .proto_err     (proto_err)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int errors = 0;
  int checks = 0;

  // Reference model: history of ready-cycle samples plus burst bookkeeping
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic        q_wr[$];
  int          m_err;       // 0 none, 1 first error cycle, 2 second error cycle
  bit          m_proto;
  bit          m_in_burst;
  int          m_len;       // beats in burst, 0 = unbounded
  int          m_kind;      // 0 single, 1 incrementing, 2 wrapping
  int          m_count;     // beats accepted so far
  longint      m_prev;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int region_of(input logic [31:0] a);
    longint base;
    for (int k = 0; k < 3; k++) begin
      base = 64'h8000_0000 + longint'(k) * 64'h0400_0000;
      if (longint'(a) >= base && longint'(a) < base + 64'h0400_0000) return k;
    end
    return -1;
  endfunction

  function automatic int burst_len(input int hb);
    case (hb)
      0: return 1;
      1: return 0;
      2, 3: return 4;
      4, 5: return 8;
      default: return 16;
    endcase
  endfunction

  function automatic logic exp_ready(input logic hrb);
    if (m_err == 1) return 1'b0;
    if (m_err == 2) return 1'b1;
    return hrb;
  endfunction

  task automatic model_reset();
    q_addr = {32'h0, 32'h0};
    q_data = {32'h0, 32'h0};
    q_wr   = {1'b0, 1'b0};
    m_err = 0; m_proto = 0; m_in_burst = 0;
    m_len = 0; m_kind = 0; m_count = 0; m_prev = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".haddr_1"},  haddr_1,  q_addr[0]);
    chk({tag, ".haddr_2"},  haddr_2,  q_addr[1]);
    chk({tag, ".hwdata_1"}, hwdata_1, q_data[0]);
    chk({tag, ".hwdata_2"}, hwdata_2, q_data[1]);
    chk({tag, ".hwrite_reg"},   hwrite_reg,   q_wr[0]);
    chk({tag, ".hwrite_reg_1"}, hwrite_reg_1, q_wr[1]);
    chk({tag, ".proto_err"}, proto_err, m_proto);
  endtask

  // One bus cycle, entered and left just after a rising edge.
  // hrin < 0 means the master follows the expected hreadyout.
  task automatic cycle(input string tag, input logic [1:0] tr, input logic wr,
                       input logic [2:0] sz, input logic [2:0] hb, input logic [31:0] a,
                       input logic [31:0] wd, input int hrin, input logic hrb,
                       output logic took);
    int rgn, nerr;
    bit acc, viol;
    longint inc, span;
    htrans = tr; hwrite = wr; hsize = sz; hburst = hb; haddr = a; hwdata = wd;
    hready_bridge = hrb;
    hreadyin = (hrin < 0) ? exp_ready(hrb) : hrin[0];
    hrdata_bridge = $urandom;
    took = hreadyin;
    #1;
    rgn = region_of(a);
    acc = hreadyin && (tr >= 2) && (m_err == 0);
    chk({tag, ".valid"}, valid, acc && rgn >= 0);
    chk({tag, ".tempselx"}, tempselx, (rgn >= 0) ? (64'd1 << rgn) : 64'd0);
    chk({tag, ".hreadyout"}, hreadyout, exp_ready(hrb));
    chk({tag, ".hresp"}, hresp, (m_err != 0) ? 64'd1 : 64'd0);
    chk({tag, ".hrdata"}, hrdata, hrdata_bridge);
    viol = 0;
    if (acc && tr == 2'd3) begin
      inc = longint'(1) << sz;
      if (!m_in_burst) viol = 1;
      else begin
        if (m_len != 0 && m_count >= m_len) viol = 1;
        if (m_kind == 1 && (m_prev + inc > 64'hFFFF_FFFF || m_prev + inc != longint'(a))) viol = 1;
        if (m_kind == 2) begin
          span = longint'(m_len) * inc;
          if (m_prev / span != longint'(a) / span) viol = 1;
        end
      end
    end
    if (m_err == 1) nerr = 2;
    else if (m_err == 2) nerr = 0;
    else if (ERR_EN && acc && (rgn < 0 || viol)) nerr = 1;
    else nerr = 0;
    if (acc && tr == 2'd2) begin
      m_in_burst = 1; m_len = burst_len(hb); m_count = 1; m_prev = a;
      m_kind = (hb == 3'd0) ? 0 : (hb[0] ? 1 : 2);
    end else if (acc && tr == 2'd3) begin
      m_count++; m_prev = a;
    end else if (hreadyin && tr == 2'd0) begin
      m_in_burst = 0;
    end
    if (hreadyin) begin
      q_addr.push_front(a);  void'(q_addr.pop_back());
      q_data.push_front(wd); void'(q_data.pop_back());
      q_wr.push_front(wr);   void'(q_wr.pop_back());
    end
    if (viol) m_proto = 1;
    @(posedge hclk); #1;
    m_err = nerr;
    check_regs(tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".valid"}, valid, 0);
    chk({tag, ".tempselx"}, tempselx, 0);
    chk({tag, ".hreadyout"}, hreadyout, 1);
    chk({tag, ".hresp"}, hresp, 0);
    check_regs(tag);
  endtask

  // Asserts reset without waiting for a clock, checks, then releases it
  task automatic do_reset(input string tag);
    hresetn = 1'b0;
    model_reset();
    #1;
    check_reset_values(tag);
    htrans = 2'd0; haddr = '0; hwdata = '0; hwrite = 1'b0; hreadyin = 1'b1;
    hready_bridge = 1'b1;
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    hresetn = 1'b1;
  endtask

  logic        t;
  logic [31:0] addrs[$];

  initial begin
    hresetn = 1'b0; hwrite = 0; hreadyin = 1; htrans = 0; hsize = 0; hburst = 0;
    haddr = 0; hwdata = 0; hready_bridge = 1; hrdata_bridge = 0;
    model_reset();
    repeat (2) @(posedge hclk);
    #1;
    check_reset_values("reset");
    hresetn = 1'b1;

    // Single write to region 1, write data in the following cycle
    cycle("single_a", 2'd2, 1, 3'd2, 3'd0, 32'h8400_0000, 32'h0, 1, 1, t);
    chk("single.haddr_1", haddr_1, 32'h8400_0000);
    cycle("single_d", 2'd0, 0, 3'd2, 3'd0, 32'h0, 32'h29, 1, 1, t);
    chk("single.hwdata_1", hwdata_1, 32'h29);

    // INCR4 byte write in region 0
    cycle("incr4", 2'd2, 1, 3'd0, 3'd3, 32'h8000_0000, 32'h0, 1, 1, t);
    for (int i = 1; i < 4; i++)
      cycle("incr4", 2'd3, 1, 3'd0, 3'd3, 32'h8000_0000 + i, 32'h10 + i, 1, 1, t);
    cycle("incr4_end", 2'd0, 0, 3'd0, 3'd0, 32'h0, 32'h14, 1, 1, t);
    chk("incr4.proto_err", proto_err, 0);

    // Unmapped read followed by idle cycles while the response plays out
    cycle("unmapped", 2'd2, 0, 3'd2, 3'd0, 32'h9000_0000, 32'h0, 1, 1, t);
    for (int i = 0; i < 3; i++)
      cycle("unmapped_idle", 2'd0, 0, 3'd0, 3'd0, 32'h0, 32'h0, -1, 1, t);

    // Stalled INCR4: bridge not ready, master holds off
    cycle("stall", 2'd2, 1, 3'd2, 3'd3, 32'h8800_0100, 32'h0, 1, 1, t);
    cycle("stall", 2'd3, 1, 3'd2, 3'd3, 32'h8800_0104, 32'hA1, 1, 1, t);
    for (int i = 0; i < 3; i++)
      cycle("stall_hold", 2'd3, 1, 3'd2, 3'd3, 32'h8800_0108, 32'hA2, 0, 0, t);
    cycle("stall", 2'd3, 1, 3'd2, 3'd3, 32'h8800_0108, 32'hA2, 1, 1, t);
    cycle("stall", 2'd3, 1, 3'd2, 3'd3, 32'h8800_010C, 32'hA3, 1, 1, t);
    cycle("stall_end", 2'd0, 0, 3'd0, 3'd0, 32'h0, 32'hA4, -1, 1, t);
    chk("stall.proto_err", proto_err, 0);

    // Skipped address inside an INCR4 burst raises the sticky flag
    cycle("skip", 2'd2, 1, 3'd0, 3'd3, 32'h8000_0000, 32'h0, 1, 1, t);
    cycle("skip", 2'd3, 1, 3'd0, 3'd3, 32'h8000_0002, 32'h0, -1, 1, t);
    chk("skip.proto_err", proto_err, 1);
    for (int i = 0; i < 4; i++)
      cycle("skip_idle", 2'd0, 0, 3'd0, 3'd0, 32'h0, 32'h0, -1, 1, t);
    chk("skip.proto_err_sticky", proto_err, 1);

    // Reset in the middle of a burst, then a fresh transfer
    do_reset("skip_reset");
    cycle("mid", 2'd2, 1, 3'd1, 3'd3, 32'h8000_0040, 32'h0, 1, 1, t);
    cycle("mid", 2'd3, 1, 3'd1, 3'd3, 32'h8000_0042, 32'h55, 1, 1, t);
    do_reset("mid_reset");
    cycle("post_reset", 2'd2, 0, 3'd2, 3'd0, 32'h8800_0000, 32'h0, 1, 1, t);
    cycle("post_reset", 2'd0, 0, 3'd0, 3'd0, 32'h0, 32'h0, 1, 1, t);

    // SEQ with no preceding NONSEQ
    cycle("orphan", 2'd3, 0, 3'd0, 3'd1, 32'h8000_0010, 32'h0, 1, 1, t);
    for (int i = 0; i < 3; i++)
      cycle("orphan_idle", 2'd0, 0, 3'd0, 3'd0, 32'h0, 32'h0, -1, 1, t);
    do_reset("orphan_reset");

    // Random bursts with busy cycles, stalls and occasional rule breaks
    for (int b = 0; b < 60; b++) begin
      int hb, sz, len, rgn, corrupt, tries;
      logic [31:0] a, inc, span, start;
      hb  = $urandom_range(0, 7);
      sz  = $urandom_range(0, 2);
      len = burst_len(hb);
      if (len == 0) len = $urandom_range(1, 6);
      rgn = $urandom_range(0, 2);
      inc = 32'd1 << sz;
      start = 32'h8000_0000 + rgn * 32'h0400_0000 + ($urandom & 32'h0003_FFFF);
      start = start & ~(inc - 32'd1);
      corrupt = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
      addrs = {};
      a = start;
      for (int i = 0; i < len + ((corrupt == 2) ? 1 : 0); i++) begin
        addrs.push_back(a);
        if (hb != 1 && hb[0] == 1'b0 && hb != 0) begin
          span = inc * burst_len(hb);
          a = (a & ~(span - 1)) | ((a + inc) & (span - 1));
        end else begin
          a = a + inc;
        end
      end
      if (corrupt == 1 && addrs.size() > 1) addrs[1] = addrs[1] + (hb[0] ? inc : inc * 32);
      if ($urandom_range(0, 9) == 0) begin
        addrs = {($urandom_range(0, 1) != 0) ? 32'h0000_1000 : 32'hA000_0000};
        hb = 0;
      end
      for (int i = 0; i < addrs.size(); i++) begin
        tries = 0;
        if (i > 0 && $urandom_range(0, 4) == 0)
          cycle("rnd_busy", 2'd1, 1, sz[2:0], hb[2:0], addrs[i], $urandom, -1, 1, t);
        do begin
          cycle("rnd", (i == 0) ? 2'd2 : 2'd3, b[0], sz[2:0], hb[2:0], addrs[i], $urandom,
                -1, ($urandom_range(0, 5) != 0), t);
          tries++;
        end while (!t && tries < 20);
        if (!t) begin
          errors++; checks++;
          $display("FAIL rnd_timeout observed=stalled expected=accepted");
        end
        if (m_err != 0) break;
      end
      for (int i = 0; i < 3; i++)
        cycle("rnd_idle", 2'd0, 0, 3'd0, 3'd0, 32'h0, $urandom, -1, 1, t);
      if (b % 15 == 14) do_reset("rnd_reset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
